// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package : cpu_pkg
//  Shared types and constants for the core's controller-side blocks.
//  Rev 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Instruction word width, matches the controller's IR input.
  localparam int IR_W = 16;

  // Opcode loaded into IR when a fetch is abandoned by the watchdog.
  localparam logic [IR_W-1:0] NOP_OPCODE = 16'h0000;

  // Fetch sequencer states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ifu_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface : instr_fetch_unit_if
//  Instruction memory read channel (request / valid handshake).
//  master = fetch unit, slave = instruction RAM.
//  Rev 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int IR_W   = 16
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [IR_W-1:0]   mem_rdata;
  logic              mem_valid;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_valid
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_valid
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module : pc_counter
//  Program counter register. A load wins outright; otherwise the PC advances
//  by the sum of the fetch-completion and control-word increments, wrapping
//  modulo 2^ADDR_W.
//  Rev 1.0 - initial release
// ============================================================================
module pc_counter #(
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              load,
  input  wire logic [ADDR_W-1:0] load_val,
  input  wire logic              inc_done,
  input  wire logic              inc_ctl,
  output logic [ADDR_W-1:0]      pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [1:0]        step;

  // Next PC: load has priority, else add 0, 1 or 2 (natural wrap).
  always_comb begin
    step = {1'b0, inc_done} + {1'b0, inc_ctl};
    if (load) begin
      pc_d = load_val;
    end else begin
      pc_d = pc_q + ADDR_W'(step);
    end
  end

  // PC register with synchronous reset to address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : instr_fetch_unit
//  Owns PC and IR. Issues one instruction-memory read per fetch request,
//  latches the returned word into IR and pulses ir_valid.
//  Optional macro IFU_TIMEOUT_EN: abandons a fetch after TIMEOUT cycles in
//  WAIT, loads NOP into IR and sets the sticky err flag.
//  Rev 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int IR_W    = 16,
  parameter int TIMEOUT = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              fetch_req,
  input  wire logic              pc_inc,
  input  wire logic              pc_load,
  input  wire logic [ADDR_W-1:0] pc_load_val,
  instr_fetch_unit_if.master     mem,
  output logic [IR_W-1:0]        IR,
  output logic                   ir_valid,
  output logic                   busy,
  output logic [ADDR_W-1:0]      pc,
  output logic                   err
);

  import cpu_pkg::*;

  ifu_state_t        state_q, state_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              done;
  logic              tmo;
  logic [ADDR_W-1:0] fetch_addr;

  // A jump in the request cycle is fetched directly, not the stale PC.
  assign fetch_addr = pc_load ? pc_load_val : pc;
  assign done       = (state_q == WAIT) && mem.mem_valid;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc_done (done),
    .inc_ctl  (pc_inc),
    .pc       (pc)
  );

`ifdef IFU_TIMEOUT_EN
  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  // Expiry on the TIMEOUT-th WAIT cycle; valid data in that cycle wins.
  assign tmo = (state_q == WAIT) && !mem.mem_valid &&
               (cnt_q == c_cnt_w'(TIMEOUT - 1));

  // Counter held at zero in IDLE so every WAIT starts from a clean count.
  always_comb begin
    cnt_d = '0;
    err_d = err_q | tmo;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;

  // TIMEOUT only matters with the watchdog built in.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // Next state: requests are only taken in IDLE; WAIT ends on data or expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_req) state_d = WAIT;
      WAIT:    if (mem.mem_valid || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; address is captured once and held for the fetch.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = fetch_addr;
        end
      end
      WAIT: begin
        if (mem.mem_valid) begin
          ir_d       = mem.mem_rdata;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
        end else if (tmo) begin
          ir_d       = IR_W'(NOP_OPCODE);
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
        end
      end
      default: mem_rd_d = 1'b0;
    endcase
  end

  assign mem.mem_rd   = mem_rd_q;
  assign mem.mem_addr = mem_addr_q;
  assign IR           = ir_q;
  assign ir_valid     = ir_valid_q;
  assign busy         = mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_instr_fetch_unit
//  Directed, table-driven bench for instr_fetch_unit plus hand-written
//  multi-cycle sequences (slow memory, stalled fetch / watchdog).
//  Rev 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic        pc_inc;
  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [15:0] IR;
  logic        ir_valid;
  logic        busy;
  logic [7:0]  pc;
  logic        err;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit_if #(.ADDR_W(8), .IR_W(16)) mem_if ();

  instr_fetch_unit #(
    .ADDR_W  (8),
    .IR_W    (16),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .mem         (mem_if),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .busy        (busy),
    .pc          (pc),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fr;
    logic        inc;
    logic        ld;
    logic [7:0]  lv;
    logic        mv;
    logic [15:0] rdata;
    logic        e_rd;
    logic [7:0]  e_addr;
    logic [15:0] e_ir;
    logic        e_iv;
    logic [7:0]  e_pc;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mkv(logic rst, logic fr, logic inc, logic ld,
                               logic [7:0] lv, logic mv, logic [15:0] rdata,
                               logic e_rd, logic [7:0] e_addr, logic [15:0] e_ir,
                               logic e_iv, logic [7:0] e_pc);
    vec_t v;
    v.rst = rst; v.fr = fr; v.inc = inc; v.ld = ld; v.lv = lv;
    v.mv = mv; v.rdata = rdata; v.e_rd = e_rd; v.e_addr = e_addr;
    v.e_ir = e_ir; v.e_iv = e_iv; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic fr, input logic inc,
                       input logic ld, input logic [7:0] lv,
                       input logic mv, input logic [15:0] rdata);
    reset              = rst;
    fetch_req          = fr;
    pc_inc             = inc;
    pc_load            = ld;
    pc_load_val        = lv;
    mem_if.mem_valid   = mv;
    mem_if.mem_rdata   = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    tick();
    idle_inputs();
  endtask

  initial begin
    int rd_cnt;
    int busy_cnt;
    int iv_cnt;

    //          rst fr inc ld lv     mv rdata      e_rd e_addr e_ir      e_iv e_pc
    vecs[0]  = mkv(1, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00); // reset
    vecs[1]  = mkv(0, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00); // idle
    vecs[2]  = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 16'h0000, 0, 8'h00); // fetch @0
    vecs[3]  = mkv(0, 0, 0, 0, 8'h00, 1, 16'h1234, 0, 8'h00, 16'h1234, 1, 8'h01); // data
    vecs[4]  = mkv(0, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h1234, 0, 8'h01); // hold
    vecs[5]  = mkv(0, 0, 1, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h1234, 0, 8'h02); // pc_inc
    vecs[6]  = mkv(0, 0, 1, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h1234, 0, 8'h03); // pc_inc
    vecs[7]  = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h03, 16'h1234, 0, 8'h03); // fetch @3
    vecs[8]  = mkv(0, 0, 1, 0, 8'h00, 1, 16'hA5A5, 0, 8'h03, 16'hA5A5, 1, 8'h05); // data+inc
    vecs[9]  = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h05, 16'hA5A5, 0, 8'h05); // b2b fetch
    vecs[10] = mkv(0, 0, 0, 0, 8'h00, 1, 16'h0F0F, 0, 8'h05, 16'h0F0F, 1, 8'h06);
    vecs[11] = mkv(0, 1, 0, 1, 8'h40, 0, 16'h0000, 1, 8'h40, 16'h0F0F, 0, 8'h40); // jump bypass
    vecs[12] = mkv(0, 0, 0, 0, 8'h00, 1, 16'h4444, 0, 8'h40, 16'h4444, 1, 8'h41);
    vecs[13] = mkv(0, 0, 0, 1, 8'hFF, 0, 16'h0000, 0, 8'h40, 16'h4444, 0, 8'hFF); // load FF
    vecs[14] = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'hFF, 16'h4444, 0, 8'hFF); // fetch @FF
    vecs[15] = mkv(0, 0, 0, 0, 8'h00, 1, 16'hFFFE, 0, 8'hFF, 16'hFFFE, 1, 8'h00); // wrap
    vecs[16] = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 16'hFFFE, 0, 8'h00);
    vecs[17] = mkv(0, 0, 0, 1, 8'h20, 0, 16'h0000, 1, 8'h00, 16'hFFFE, 0, 8'h20); // load in WAIT
    vecs[18] = mkv(0, 0, 0, 1, 8'h30, 1, 16'h7777, 0, 8'h00, 16'h7777, 1, 8'h30); // load at done
    vecs[19] = mkv(0, 0, 0, 0, 8'h00, 1, 16'h9999, 0, 8'h00, 16'h7777, 0, 8'h30); // stray valid
    vecs[20] = mkv(0, 1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h30, 16'h7777, 0, 8'h30);
    vecs[21] = mkv(1, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00); // reset in WAIT
    vecs[22] = mkv(0, 0, 0, 0, 8'h00, 1, 16'hBEEF, 0, 8'h00, 16'h0000, 0, 8'h00); // late valid
    vecs[23] = mkv(0, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 16'h0000, 0, 8'h00);

    idle_inputs();
    reset = 1'b1;

    // ---- table-driven sequence ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].fr, vecs[i].inc, vecs[i].ld, vecs[i].lv,
            vecs[i].mv, vecs[i].rdata);
      tick();
      chk($sformatf("v%0d mem_rd", i),   32'(mem_if.mem_rd),   32'(vecs[i].e_rd));
      chk($sformatf("v%0d busy", i),     32'(busy),            32'(vecs[i].e_rd));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_if.mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d IR", i),       32'(IR),              32'(vecs[i].e_ir));
      chk($sformatf("v%0d ir_valid", i), 32'(ir_valid),        32'(vecs[i].e_iv));
      chk($sformatf("v%0d pc", i),       32'(pc),              32'(vecs[i].e_pc));
      chk($sformatf("v%0d err", i),      32'(err),             32'd0);
    end

    // ---- slow memory: valid 5 cycles after mem_rd, fetch_req pulse mid-WAIT ----
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    tick();
    rd_cnt = 0; busy_cnt = 0; iv_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      if (mem_if.mem_rd) rd_cnt++;
      if (busy) busy_cnt++;
      if (ir_valid) iv_cnt++;
      drive(1'b0, (n == 2), 1'b0, 1'b0, 8'h00, (n == 4), 16'hC0DE);
      tick();
    end
    chk("slow mem_rd cycles", 32'(rd_cnt), 32'd5);
    chk("slow busy cycles", 32'(busy_cnt), 32'd5);
    chk("slow ir_valid pulses", 32'(iv_cnt), 32'd1);
    chk("slow IR", 32'(IR), 32'h0000C0DE);
    chk("slow pc", 32'(pc), 32'd1);
    chk("slow mem_rd idle", 32'(mem_if.mem_rd), 32'd0);

    // ---- stalled fetch: watchdog abort or indefinite wait ----
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h5555);
    tick();
    chk("stall prep IR", 32'(IR), 32'h00005555);
    idle_inputs();
    fetch_req = 1'b1;
    tick();
    idle_inputs();
`ifdef IFU_TIMEOUT_EN
    rd_cnt = 0; iv_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      if (mem_if.mem_rd) rd_cnt++;
      tick();
      if (ir_valid) begin
        iv_cnt++;
        chk("tmo IR nop", 32'(IR), 32'd0);
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo pc", 32'(pc), 32'd1);
        chk("tmo mem_rd", 32'(mem_if.mem_rd), 32'd0);
      end
    end
    chk("tmo wait cycles", 32'(rd_cnt), 32'd4);
    chk("tmo ir_valid pulses", 32'(iv_cnt), 32'd1);
    chk("tmo err sticky", 32'(err), 32'd1);
    do_reset();
    chk("tmo err cleared", 32'(err), 32'd0);
`else
    for (int n = 0; n < 20; n++) tick();
    chk("stall mem_rd held", 32'(mem_if.mem_rd), 32'd1);
    chk("stall busy held", 32'(busy), 32'd1);
    chk("stall no err", 32'(err), 32'd0);
    chk("stall IR held", 32'(IR), 32'h00005555);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'h6666);
    tick();
    idle_inputs();
    chk("stall late IR", 32'(IR), 32'h00006666);
    chk("stall late pc", 32'(pc), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
